uart_transmitter: RTL and testbench

Serialises one byte per request onto a UART line. The line carries: start bit, 8 data bits LSB first, optional parity bit, stop bit. The block sits directly upstream of UART_Receiver: its `out` drives the receiver's `in`, using the same bit period and frame format. It is driven from the APB/GPIO side by a start strobe and a parallel byte.

---
 rtl/uart_transmitter.sv | 128 ++++++++++++
 tb/tb_uart_transmitter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART serialiser: start bit, 8 data bits LSB first, optional parity, one stop bit.
// The line and all status outputs are registered; enable=0 freezes the frame in progress.
module uart_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_EN    = 1'b1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       enable,
    input  logic       TX_start,
    input  logic [7:0] data_in,
    output logic       out,
    output logic       TX_busy,
    output logic       TX_done,
    output logic [2:0] state_dbg
);

    // Handshake: TX_start acts as valid and !TX_busy as ready. A request is taken
    // only at an edge where the FSM is IDLE and enable=1; while busy it is dropped,
    // never queued. TX_done is a one-cycle completion pulse, not a handshake.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] baud_cnt;
    logic [15:0] baud_next;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;
    logic        parity_bit;
    logic        parity_next;
    logic        out_next;
    logic        busy_next;
    logic        done_next;
    logic        accept;
    logic        bit_tick;

    assign accept    = (state == IDLE) && enable && TX_start;
    assign bit_tick  = (state != IDLE) && enable && (baud_cnt == BAUD_LAST);
    assign state_dbg = state;

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            out        <= 1'b1;
            TX_busy    <= 1'b0;
            TX_done    <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_idx    <= bit_idx_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            out        <= out_next;
            TX_busy    <= busy_next;
            TX_done    <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (bit_tick) state_next = DATA;
            DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) begin
                    state_next = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY:  if (bit_tick) state_next = STOP;
            STOP:    if (bit_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Baud counter, bit index, shift register and parity latch.
    always_comb begin
        baud_next    = baud_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        parity_next  = parity_bit;
        if (accept) begin
            baud_next    = '0;
            bit_idx_next = '0;
            shift_next   = data_in;
            parity_next  = (^data_in) ^ PARITY_ODD;
        end else if (state != IDLE && enable) begin
            if (bit_tick) begin
                baud_next = '0;
                if (state == DATA) begin
                    bit_idx_next = bit_idx + 3'd1;
                    shift_next   = {1'b0, shift_reg[7:1]};
                end
            end else begin
                baud_next = baud_cnt + 16'd1;
            end
        end
    end

    // Line level follows the state being entered so it changes on the same edge.
    always_comb begin
        out_next  = 1'b1;
        busy_next = (state_next != IDLE);
        done_next = (state == STOP) && bit_tick;
        case (state_next)
            START:   out_next = 1'b0;
            DATA:    out_next = shift_next[0];
            PARITY:  out_next = parity_next;
            default: out_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances (even, odd, no parity) share
// stimulus; each frame is compared cycle by cycle against a hand-built expected line.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       tx_start;
  logic [7:0] data_in;

  logic       out_e, busy_e, done_e;
  logic       out_o, busy_o, done_o;
  logic       out_n, busy_n, done_n;
  logic [2:0] st_e, st_o, st_n;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_e (
    .clk(clk), .RST(rst), .enable(enable), .TX_start(tx_start), .data_in(data_in),
    .out(out_e), .TX_busy(busy_e), .TX_done(done_e), .state_dbg(st_e)
  );

  uart_transmitter #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_o (
    .clk(clk), .RST(rst), .enable(enable), .TX_start(tx_start), .data_in(data_in),
    .out(out_o), .TX_busy(busy_o), .TX_done(done_o), .state_dbg(st_o)
  );

  uart_transmitter #(.CLKS_PER_BIT(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_n (
    .clk(clk), .RST(rst), .enable(enable), .TX_start(tx_start), .data_in(data_in),
    .out(out_n), .TX_busy(busy_n), .TX_done(done_n), .state_dbg(st_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel_out(input int sel);
    return (sel == 0) ? out_e : (sel == 1) ? out_o : out_n;
  endfunction

  function automatic logic sel_busy(input int sel);
    return (sel == 0) ? busy_e : (sel == 1) ? busy_o : busy_n;
  endfunction

  function automatic logic sel_done(input int sel);
    return (sel == 0) ? done_e : (sel == 1) ? done_o : done_n;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_e | busy_o | busy_n) === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 500), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Sends one byte and follows the selected instance until TX_busy falls.
  // stall_at/stall_len drop enable for a window; collide_at pulses TX_start with 0x55.
  task automatic run_frame(input string tag, input int sel, input logic [7:0] b,
                           input logic par, input bit has_par, input int stall_at,
                           input int stall_len, input int collide_at);
    logic [10:0] bits;
    int          mids[11];
    int          nbits;
    int          pos;
    int          dur;
    int          s;
    int          mism;
    int          done_early;
    logic        line_s[$];
    logic        e;
    logic [7:0]  rx;

    nbits = has_par ? 11 : 10;
    bits  = has_par ? {1'b1, par, b, 1'b0} : {1'b1, 1'b1, b, 1'b0};
    pos   = 0;
    exp_q.delete();
    for (int k = 0; k < nbits; k++) begin
      dur = 16;
      if (stall_len > 0 && stall_at >= pos && stall_at < pos + 16) dur = 16 + stall_len;
      mids[k] = pos + dur / 2;
      for (int c = 0; c < dur; c++) exp_q.push_back(bits[k]);
      pos += dur;
    end

    @(negedge clk);
    data_in  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start   = 1'b0;
    s          = 0;
    mism       = 0;
    done_early = 0;
    while (sel_busy(sel) === 1'b1 && s < 400) begin
      line_s.push_back(sel_out(sel));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (sel_out(sel) !== e) mism++;
      end else begin
        mism++;
      end
      if (sel_done(sel) !== 1'b0) done_early++;
      enable = !(stall_len > 0 && s >= stall_at && s < stall_at + stall_len);
      if (s == collide_at) begin
        tx_start = 1'b1;
        data_in  = 8'h55;
      end else begin
        tx_start = 1'b0;
      end
      @(negedge clk);
      s++;
    end
    enable   = 1'b1;
    tx_start = 1'b0;
    mism += exp_q.size();

    check({tag, "_line"}, mism, 0);
    check({tag, "_busy_len"}, s, pos);
    check({tag, "_done_early"}, done_early, 0);
    check({tag, "_done_end"}, sel_done(sel), 1);
    check({tag, "_idle_line"}, sel_out(sel), 1);
    for (int i = 0; i < 8; i++) rx[i] = (mids[i + 1] < line_s.size()) ? line_s[mids[i + 1]] : 1'bx;
    check({tag, "_rx_byte"}, rx, b);
    if (has_par) check({tag, "_parity"}, (mids[9] < line_s.size()) ? line_s[mids[9]] : 1'bx, par);
    @(negedge clk);
    check({tag, "_done_width"}, sel_done(sel), 0);
  endtask

  initial begin
    int dcount;
    rst      = 1'b1;
    enable   = 1'b1;
    tx_start = 1'b1;
    data_in  = 8'hFF;

    // Reset held with TX_start high: nothing may start.
    repeat (3) begin
      @(negedge clk);
      check("rst_out", out_e & out_o & out_n, 1);
      check("rst_busy", busy_e | busy_o | busy_n, 0);
      check("rst_done", done_e | done_o | done_n, 0);
      check("rst_state", st_e, 0);
    end
    rst      = 1'b0;
    tx_start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy_e, 0);

    run_frame("dff_even", 0, 8'hDF, 1'b1, 1'b1, -1, 0, -1);
    wait_idle();
    run_frame("dff_odd", 1, 8'hDF, 1'b0, 1'b1, -1, 0, -1);
    wait_idle();
    run_frame("zero_even", 0, 8'h00, 1'b0, 1'b1, -1, 0, -1);
    wait_idle();
    run_frame("zero_odd", 1, 8'h00, 1'b1, 1'b1, -1, 0, -1);
    wait_idle();
    run_frame("zero_nopar", 2, 8'h00, 1'b0, 1'b0, -1, 0, -1);
    wait_idle();

    // Second request during DATA must be ignored.
    run_frame("collide", 0, 8'hA5, 1'b0, 1'b1, -1, 0, 40);
    repeat (20) @(negedge clk);
    check("collide_no_refire", busy_e, 0);
    wait_idle();

    // enable low for 10 cycles inside data bit 3 (cycles 64..79).
    run_frame("stall", 0, 8'hDF, 1'b1, 1'b1, 72, 10, -1);
    wait_idle();

    // Reset during the parity bit (cycles 144..159) of 0x3C.
    @(negedge clk);
    data_in  = 8'h3C;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (150) @(negedge clk);
    check("pre_rst_state", st_e, 3);
    check("pre_rst_parity", out_e, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", out_e, 1);
    check("midrst_busy", busy_e, 0);
    check("midrst_done", done_e, 0);
    check("midrst_state", st_e, 0);
    dcount = 0;
    repeat (200) begin
      @(negedge clk);
      if (done_e !== 1'b0) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    run_frame("post_rst", 0, 8'h3C, 1'b0, 1'b1, -1, 0, -1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
